// File: rtl/fg_pkg.sv
// Shared definitions for the flow generator blocks.
//   - fg_sched_state_e : scheduler state encoding (FG_SCHED_IDLE/WAIT/ISSUE)
//   - FG_BAL_WIDTH     : width of the signed rate-limiter balance
//   - FG_LEN_WIDTH     : width of flow and burst byte lengths
//   - fg_min_len()     : unsigned minimum of two lengths
package fg_pkg;

    localparam int FG_BAL_WIDTH = 50;
    localparam int FG_LEN_WIDTH = 32;

    typedef enum logic [1:0] {
        FG_SCHED_IDLE  = 2'd0,
        FG_SCHED_WAIT  = 2'd1,
        FG_SCHED_ISSUE = 2'd2
    } fg_sched_state_e;

    function automatic logic [FG_LEN_WIDTH-1:0] fg_min_len(
        input logic [FG_LEN_WIDTH-1:0] a,
        input logic [FG_LEN_WIDTH-1:0] b
    );
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/fg_rate_limiter.sv
// Leaky-bucket rate limiter for the flow scheduler.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   load       : hold the balance at zero (scheduler idle / new flow)
//   num, denom : rate numerator (bytes) and denominator (clocks)
//   issue      : a burst handshake happens this clock
//   issue_len  : byte length of the burst being handed over
//   go         : the next burst may be issued (unthrottled or balance >= 0)
module fg_rate_limiter
    import fg_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [15:0]             num,
    input  logic [15:0]             denom,
    input  logic                    issue,
    input  logic [FG_LEN_WIDTH-1:0] issue_len,
    output logic                    go
);

    logic signed [FG_BAL_WIDTH-1:0] bal_q;
    logic signed [FG_BAL_WIDTH-1:0] bal_d;
    logic signed [FG_BAL_WIDTH-1:0] sum;
    logic signed [FG_BAL_WIDTH-1:0] clamped;
    logic signed [FG_BAL_WIDTH-1:0] cost;
    logic        [47:0]             product;
    logic                           unthrottled;

    always_comb begin
        product     = {16'd0, issue_len} * {32'd0, denom};
        sum         = bal_q + $signed({34'd0, num});
        // Credit never rises above zero, so stalls cannot bank bandwidth.
        clamped     = sum[FG_BAL_WIDTH-1] ? sum : '0;
        cost        = issue ? $signed({2'b00, product}) : '0;
        bal_d       = load ? '0 : (clamped - cost);
        unthrottled = (num == 16'd0) || (denom == 16'd0);
        // Deciding on the post-update balance covers both the ISSUE case
        // (with the handshake cost) and the WAIT case (accrual only).
        go          = unthrottled || !bal_d[FG_BAL_WIDTH-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bal_q <= '0;
        end else begin
            bal_q <= bal_d;
        end
    end

endmodule

// File: rtl/fg_fd_scheduler.sv
// Flow scheduler: accepts one flow descriptor at a time and splits the flow
// into burst descriptors of at most burst_len bytes, paced by fg_rate_limiter
// so the flow averages rate_num/rate_denom bytes per clock.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   input_fd_*               : flow descriptor handshake (ready only in IDLE)
//   output_bd_*              : registered burst descriptor handshake
//   busy                     : scheduler is working on a flow
// Optional (macro FG_FD_SCHEDULER_STATS_EN):
//   stat_burst_count [31:0]  : free-running count of burst handshakes
//   stat_byte_count  [63:0]  : free-running sum of handed-over burst bytes
module fg_fd_scheduler
    import fg_pkg::*;
#(
    parameter int DEST_WIDTH = 8
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    input_fd_valid,
    output logic                    input_fd_ready,
    input  logic [DEST_WIDTH-1:0]   input_fd_dest,
    input  logic [15:0]             input_fd_rate_num,
    input  logic [15:0]             input_fd_rate_denom,
    input  logic [FG_LEN_WIDTH-1:0] input_fd_len,
    input  logic [FG_LEN_WIDTH-1:0] input_fd_burst_len,
    output logic                    output_bd_valid,
    input  logic                    output_bd_ready,
    output logic [DEST_WIDTH-1:0]   output_bd_dest,
    output logic [FG_LEN_WIDTH-1:0] output_bd_len,
    output logic                    busy
`ifdef FG_FD_SCHEDULER_STATS_EN
    ,
    output logic [31:0]             stat_burst_count,
    output logic [63:0]             stat_byte_count
`endif
);

    fg_sched_state_e          state_q, state_d;
    logic [FG_LEN_WIDTH-1:0]  rem_q, rem_d;
    logic [FG_LEN_WIDTH-1:0]  blen_q, blen_d;
    logic [15:0]              num_q, num_d;
    logic [15:0]              denom_q, denom_d;
    logic [DEST_WIDTH-1:0]    dest_q, dest_d;
    logic                     valid_q, valid_d;
    logic [FG_LEN_WIDTH-1:0]  len_q, len_d;

    logic                     accept;
    logic                     hs;
    logic                     go;
    logic [FG_LEN_WIDTH-1:0]  rem_after;
    logic [FG_LEN_WIDTH-1:0]  new_blen;

    assign input_fd_ready  = (state_q == FG_SCHED_IDLE) && !rst;
    assign output_bd_valid = valid_q;
    assign output_bd_dest  = dest_q;
    assign output_bd_len   = len_q;
    assign busy            = (state_q != FG_SCHED_IDLE);

    fg_rate_limiter u_rate (
        .clk       (clk),
        .rst       (rst),
        .load      (state_q == FG_SCHED_IDLE),
        .num       (num_q),
        .denom     (denom_q),
        .issue     (hs),
        .issue_len (len_q),
        .go        (go)
    );

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        blen_d    = blen_q;
        num_d     = num_q;
        denom_d   = denom_q;
        dest_d    = dest_q;
        valid_d   = valid_q;
        len_d     = len_q;
        accept    = input_fd_valid && input_fd_ready;
        hs        = valid_q && output_bd_ready;
        rem_after = rem_q - len_q;
        // burst_len of zero means the whole flow goes out as one burst
        new_blen  = (input_fd_burst_len == '0) ? input_fd_len : input_fd_burst_len;

        case (state_q)
            FG_SCHED_IDLE: begin
                if (accept) begin
                    dest_d  = input_fd_dest;
                    num_d   = input_fd_rate_num;
                    denom_d = input_fd_rate_denom;
                    rem_d   = input_fd_len;
                    blen_d  = new_blen;
                    // A zero-length flow is consumed without producing a burst.
                    if (input_fd_len != '0) begin
                        state_d = FG_SCHED_ISSUE;
                        valid_d = 1'b1;
                        len_d   = fg_min_len(new_blen, input_fd_len);
                    end
                end
            end
            FG_SCHED_ISSUE: begin
                if (hs) begin
                    rem_d = rem_after;
                    if (rem_after == '0) begin
                        state_d = FG_SCHED_IDLE;
                        valid_d = 1'b0;
                    end else begin
                        len_d = fg_min_len(blen_q, rem_after);
                        if (go) begin
                            state_d = FG_SCHED_ISSUE;
                            valid_d = 1'b1;
                        end else begin
                            state_d = FG_SCHED_WAIT;
                            valid_d = 1'b0;
                        end
                    end
                end
            end
            FG_SCHED_WAIT: begin
                if (go) begin
                    state_d = FG_SCHED_ISSUE;
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = FG_SCHED_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FG_SCHED_IDLE;
            rem_q   <= '0;
            blen_q  <= '0;
            num_q   <= '0;
            denom_q <= '0;
            dest_q  <= '0;
            valid_q <= 1'b0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            blen_q  <= blen_d;
            num_q   <= num_d;
            denom_q <= denom_d;
            dest_q  <= dest_d;
            valid_q <= valid_d;
            len_q   <= len_d;
        end
    end

`ifdef FG_FD_SCHEDULER_STATS_EN
    logic [31:0] burst_cnt_q, burst_cnt_d;
    logic [63:0] byte_cnt_q, byte_cnt_d;

    assign stat_burst_count = burst_cnt_q;
    assign stat_byte_count  = byte_cnt_q;

    always_comb begin
        burst_cnt_d = burst_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        if (hs) begin
            burst_cnt_d = burst_cnt_q + 32'd1;
            byte_cnt_d  = byte_cnt_q + {32'd0, len_q};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_cnt_q <= '0;
            byte_cnt_q  <= '0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_fg_fd_scheduler.sv
// Self-checking bench for fg_fd_scheduler: table-driven flows with a burst
// scoreboard, plus hand-written reset and statistics sequences.
module tb_fg_fd_scheduler;

    typedef struct {
        logic [7:0]  dest;
        logic [31:0] len;
    } bd_t;

    typedef struct {
        int dest;
        int len;
        int blen;
        int num;
        int denom;
        int exp_n;
        int exp_gap;
        int stall;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        input_fd_valid = 1'b0;
    logic        input_fd_ready;
    logic [7:0]  input_fd_dest = '0;
    logic [15:0] input_fd_rate_num = '0;
    logic [15:0] input_fd_rate_denom = '0;
    logic [31:0] input_fd_len = '0;
    logic [31:0] input_fd_burst_len = '0;
    logic        output_bd_valid;
    logic        output_bd_ready = 1'b1;
    logic [7:0]  output_bd_dest;
    logic [31:0] output_bd_len;
    logic        busy;
`ifdef FG_FD_SCHEDULER_STATS_EN
    logic [31:0] stat_burst_count;
    logic [63:0] stat_byte_count;
`endif

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   ready_rise = 0;
    bd_t  exp_q[$];
    int   hs_cyc[$];
    vec_t vecs[9];

    fg_fd_scheduler #(.DEST_WIDTH(8)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .input_fd_valid      (input_fd_valid),
        .input_fd_ready      (input_fd_ready),
        .input_fd_dest       (input_fd_dest),
        .input_fd_rate_num   (input_fd_rate_num),
        .input_fd_rate_denom (input_fd_rate_denom),
        .input_fd_len        (input_fd_len),
        .input_fd_burst_len  (input_fd_burst_len),
        .output_bd_valid     (output_bd_valid),
        .output_bd_ready     (output_bd_ready),
        .output_bd_dest      (output_bd_dest),
        .output_bd_len       (output_bd_len),
        .busy                (busy)
`ifdef FG_FD_SCHEDULER_STATS_EN
        ,
        .stat_burst_count    (stat_burst_count),
        .stat_byte_count     (stat_byte_count)
`endif
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Output monitor: scoreboard pops on every handshake, hold checks on stalls.
    initial begin
        bd_t         e;
        logic        pstall;
        logic        prdy;
        logic [7:0]  pd;
        logic [31:0] pl;
        pstall = 1'b0;
        prdy   = 1'b0;
        pd     = '0;
        pl     = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pstall = 1'b0;
                prdy   = 1'b0;
            end else begin
                if (pstall) begin
                    chk("hold_valid", output_bd_valid, 1);
                    chk("hold_dest", output_bd_dest, pd);
                    chk("hold_len", output_bd_len, pl);
                end
                if (output_bd_valid && output_bd_ready) begin
                    hs_cyc.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        checks = checks + 1;
                        errors = errors + 1;
                        $display("FAIL bd_unexpected: got burst len %0d dest %0d, expected none",
                                 output_bd_len, output_bd_dest);
                    end else begin
                        e = exp_q.pop_front();
                        chk("bd_len", output_bd_len, e.len);
                        chk("bd_dest", output_bd_dest, e.dest);
                    end
                end
                if (input_fd_ready && !prdy) ready_rise = cyc;
                pstall = output_bd_valid && !output_bd_ready;
                pd     = output_bd_dest;
                pl     = output_bd_len;
                prdy   = input_fd_ready;
            end
        end
    end

    task automatic send_fd(input logic [7:0] d, input logic [31:0] l, input logic [31:0] bl,
                           input logic [15:0] n, input logic [15:0] dn);
        int          w;
        logic [31:0] b;
        logic [31:0] rem;
        logic [31:0] piece;
        bd_t         e;
        @(posedge clk); #1;
        input_fd_valid      = 1'b1;
        input_fd_dest       = d;
        input_fd_len        = l;
        input_fd_burst_len  = bl;
        input_fd_rate_num   = n;
        input_fd_rate_denom = dn;
        w = 0;
        while (!input_fd_ready && w < 2000) begin
            @(posedge clk); #1;
            w = w + 1;
        end
        if (!input_fd_ready) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL fd_accept_timeout: ready low for %0d cycles, expected high", w);
        end else begin
            acc_cyc = cyc;
            b   = (bl == 0) ? l : bl;
            rem = l;
            while (rem != 0) begin
                piece  = (rem < b) ? rem : b;
                e.dest = d;
                e.len  = piece;
                exp_q.push_back(e);
                rem = rem - piece;
            end
        end
        @(posedge clk); #1;
        input_fd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n = n + 1;
        end
        if (n >= budget) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL idle_timeout: busy=%0d pending=%0d after %0d cycles, expected idle",
                     busy, exp_q.size(), n);
            exp_q.delete();
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int last;
        hs_cyc.delete();
        if (v.stall > 0) output_bd_ready = 1'b0;
        send_fd(8'(v.dest), 32'(v.len), 32'(v.blen), 16'(v.num), 16'(v.denom));
        if (v.stall > 0) begin
            repeat (v.stall) @(posedge clk);
            #1;
            output_bd_ready = 1'b1;
        end
        wait_idle(5000);
        chk($sformatf("v%0d_burst_count", idx), hs_cyc.size(), v.exp_n);
        if (v.exp_n > 0 && hs_cyc.size() > 0) begin
            chk($sformatf("v%0d_first_offset", idx), hs_cyc[0] - acc_cyc, 1 + v.stall);
            for (int i = 1; i < hs_cyc.size(); i++)
                chk($sformatf("v%0d_gap%0d", idx, i), hs_cyc[i] - hs_cyc[i-1], v.exp_gap);
            last = hs_cyc[hs_cyc.size()-1];
            chk($sformatf("v%0d_ready_after_last", idx), ready_rise - last, 1);
        end else begin
            chk($sformatf("v%0d_ready_stays", idx), input_fd_ready, 1);
        end
        chk($sformatf("v%0d_busy_idle", idx), busy, 0);
    endtask

    initial begin
        // dest, len, blen, num, denom, bursts, gap, stall
        vecs[0] = '{8'h01, 256, 64, 0, 0, 4, 1,   0};
        vecs[1] = '{8'h02, 256, 64, 1, 4, 4, 257, 0};
        vecs[2] = '{8'h03, 100, 64, 0, 0, 2, 1,   0};
        vecs[3] = '{8'h04, 100, 0,  0, 0, 1, 1,   0};
        vecs[4] = '{8'h05, 0,   64, 0, 0, 0, 1,   0};
        vecs[5] = '{8'h06, 10,  4,  2, 1, 3, 3,   0};
        vecs[6] = '{8'h07, 12,  4,  8, 1, 3, 2,   0};
        vecs[7] = '{8'h08, 130, 64, 0, 5, 3, 1,   0};
        vecs[8] = '{8'hC3, 256, 64, 1, 4, 4, 257, 20};

        // Reset values while reset is held
        @(negedge clk);
        chk("rst_fd_ready", input_fd_ready, 0);
        chk("rst_bd_valid", output_bd_valid, 0);
        chk("rst_bd_dest", output_bd_dest, 0);
        chk("rst_bd_len", output_bd_len, 0);
        chk("rst_busy", busy, 0);
`ifdef FG_FD_SCHEDULER_STATS_EN
        chk("rst_stat_bursts", stat_burst_count, 0);
        chk("rst_stat_bytes", stat_byte_count, 0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_fd_ready", input_fd_ready, 1);

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Reset while the scheduler waits between bursts of a 4-burst flow
        hs_cyc.delete();
        send_fd(8'h33, 32'd256, 32'd64, 16'd1, 16'd4);
        repeat (10) @(posedge clk);
        #1;
        chk("midflow_in_wait_valid", output_bd_valid, 0);
        chk("midflow_in_wait_busy", busy, 1);
        chk("midflow_bursts_before_rst", hs_cyc.size(), 1);
        rst = 1'b1;
        #1;
        chk("midrst_bd_valid", output_bd_valid, 0);
        chk("midrst_bd_dest", output_bd_dest, 0);
        chk("midrst_bd_len", output_bd_len, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_fd_ready", input_fd_ready, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        hs_cyc.delete();
        repeat (3) @(negedge clk);
        chk("after_rst_no_burst", output_bd_valid, 0);
        chk("after_rst_fd_ready", input_fd_ready, 1);
        send_fd(8'h5A, 32'd64, 32'd64, 16'd0, 16'd0);
        wait_idle(500);
        chk("after_rst_burst_count", hs_cyc.size(), 1);
        if (hs_cyc.size() > 0) chk("after_rst_first_offset", hs_cyc[0] - acc_cyc, 1);

`ifdef FG_FD_SCHEDULER_STATS_EN
        begin
            longint b0;
            longint y0;
            b0 = stat_burst_count;
            y0 = stat_byte_count;
            send_fd(8'h11, 32'd256, 32'd64, 16'd0, 16'd0);
            wait_idle(500);
            send_fd(8'h12, 32'd256, 32'd64, 16'd0, 16'd0);
            wait_idle(500);
            chk("stat_burst_delta", longint'(stat_burst_count) - b0, 8);
            chk("stat_byte_delta", longint'(stat_byte_count) - y0, 512);
        end
`endif

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fg_fd_scheduler.md
# fg_fd_scheduler

Flow scheduler for the flow generator. Sits between the flow descriptor FIFO output and the packet builder. It accepts one flow descriptor at a time and splits the flow length into burst descriptors. Burst issue is paced by a leaky-bucket rate limiter so the flow averages rate_num/rate_denom bytes per clock.

## Interface
- DEST_WIDTH, default 8: destination field width.
- clk  input  1: clock, all logic on rising edge.
- rst  input  1: reset, asynchronous, active-high.
- input_fd_valid  input  1: flow descriptor valid.
- input_fd_ready  output  1: high only in IDLE.
- input_fd_dest  input  DEST_WIDTH: flow destination.
- input_fd_rate_num  input  16: rate numerator, bytes.
- input_fd_rate_denom  input  16: rate denominator, clocks.
- input_fd_len  input  32: total flow bytes.
- input_fd_burst_len  input  32: max bytes per burst.
- output_bd_valid  output  1: burst descriptor valid, registered.
- output_bd_ready  input  1: downstream accepts burst.
- output_bd_dest  output  DEST_WIDTH: burst destination, registered.
- output_bd_len  output  32: burst bytes, registered.
- busy  output  1: state != IDLE.

## Operation
- States: IDLE, WAIT, ISSUE.
- IDLE: input_fd_ready = 1. On accept, latch dest, num, denom, remaining = len, and blen.
  - blen = burst_len, or len when burst_len = 0.
  - Set balance = 0.
  - If len = 0: consume the descriptor, emit nothing, stay IDLE.
  - Otherwise go to ISSUE with output_bd_len = min(blen, remaining).
- ISSUE: output_bd_valid = 1. Outputs are held stable until the handshake.
  - On handshake: remaining -= output_bd_len.
  - If remaining reaches 0, go to IDLE.
  - Otherwise, when unthrottled or the next balance is ≥ 0, go to ISSUE. In all other cases go to WAIT.
  - Either way, load the next output_bd_len = min(blen, new remaining).
- WAIT: when balance + rate_num ≥ 0, go to ISSUE.
- Unthrottled means rate_num = 0 or rate_denom = 0. The balance is ignored and bursts may issue every clock.
- Balance: signed 50 bits, updated every non-IDLE clock.
  - balance_next = min(0, balance + rate_num) − (handshake ? output_bd_len × rate_denom : 0).
  - The 32×16 product is 48 bits unsigned.
  - Clamping at 0 means no credit builds up while blocked by backpressure.

## Timing
- Reset values: input_fd_ready = 0 during reset and 1 after; output_bd_valid = 0; output_bd_dest = 0; output_bd_len = 0; busy = 0; balance = 0; remaining = 0.
- Descriptor accepted in cycle t: output_bd_valid first rises at t+1.
- Throttled: after a handshake in cycle t with cost C, the next output_bd_valid rises at t+1+ceil(C/rate_num) when rate_num ≤ C.
- Final handshake in cycle t: input_fd_ready = 1 at t+1.
- Reset asserted mid-flow: the flow is dropped, every output returns to its reset value at once, and no partial burst appears after release.
- output_bd_valid never drops without a handshake.

## Configuration
- FG_FD_SCHEDULER_STATS_EN defined: adds two output ports.
  - stat_burst_count [31:0]: +1 per burst handshake.
  - stat_byte_count [63:0]: + output_bd_len per burst handshake.
  - Both are free-running and wrap, reset to 0, and are not cleared between flows.
- FG_FD_SCHEDULER_STATS_EN undefined: these ports and their logic are absent. All other behaviour is identical.

## Structure
- Shared package fg_pkg holds:
  - the state encoding constants FG_SCHED_IDLE/WAIT/ISSUE;
  - FG_BAL_WIDTH = 50 and FG_LEN_WIDTH = 32.
- Sub-module fg_rate_limiter contains the balance register, clamp, cost multiply and the go/unthrottled decision.
  - Inputs: clk, rst, load, num, denom, issue, issue_len.
  - Output: go.
- The top level holds the FSM, the remaining counter and the output registers.

## Test plan
- Unthrottled: len 256, burst_len 64, rate 0/0, ready held 1 → four bursts of 64 in consecutive cycles t+1 to t+4, then input_fd_ready = 1 at t+5.
- Throttled: len 256, burst_len 64, rate 1/4, ready held 1 → bursts of 64 with output_bd_valid at t+1, t+258, t+515 and t+772; busy drops after the last burst.
- Remainder and zero cases:
  - len 100, burst_len 64 → bursts of 64 then 36.
  - burst_len 0, len 100 → one burst of 100.
  - len 0 → no burst, ready stays 1.
- Backpressure: ready = 0 for 20 cycles in ISSUE → valid, dest and len are stable throughout; balance stays clamped at 0; the next gap is unchanged.
- Reset mid-flow: rst pulsed during WAIT of a 4-burst flow → outputs go to 0 immediately; the next descriptor (len 64, rate 0/0) gives valid at accept+1 with len 64.
- With FG_FD_SCHEDULER_STATS_EN defined: two flows of 256/64 → stat_burst_count = 8 and stat_byte_count = 512.
